// File: rtl/microwave_ctrl_gen2.sv
// Microwave oven controller: keypad mm:ss entry, BCD countdown, pause/resume, end-of-cook alarm.
// Optional magnetron duty cycling is compiled in by defining MWC_POWER_LEVEL_EN.
module microwave_ctrl_gen2 #(
  parameter int TICK_DIV    = 50000000,
  parameter int MIN_DIGITS  = 1,
  parameter int ALARM_TICKS = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [9:0]                  keypad,
  input  logic                        startn,
  input  logic                        stopn,
  input  logic                        clearn,
  input  logic                        door_closed,
`ifdef MWC_POWER_LEVEL_EN
  input  logic [3:0]                  power_level,
`endif
  output logic [4*(MIN_DIGITS+2)-1:0] digits,
  output logic                        mag_on,
  output logic                        cooking,
  output logic                        done_alarm
);

  localparam int NDIG = MIN_DIGITS + 2;
  localparam int DW   = 4 * NDIG;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int AW   = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_COOKING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_startn, r_startn_d, r_stopn, r_stopn_d, r_clearn, r_clearn_d;
  logic [9:0]      r_key, r_key_d;
  logic [DW-1:0]   r_digits;
  logic [PW-1:0]   r_presc;
  logic [AW-1:0]   r_alarm_cnt;
  logic            r_cooking, r_done_alarm;
  logic            w_start_ev, w_stop_ev, w_clear_ev, w_key_ev;
  logic            w_tick, w_gate, w_nonzero, w_last_sec, w_start_cook;
  logic            w_shift, w_norm, w_dec, w_clr_digits, w_presc_clr, w_presc_run;

  function automatic logic [3:0] key_index(input logic [9:0] k);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      idx = k[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  // Seconds tens borrow from 0 to 5; every other digit borrows from 0 to 9.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
      end else if (borrow) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Fold seconds tens of 6..9 into the minutes, saturating at max minutes:59.
  function automatic logic [DW-1:0] normalise(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          all9;
    logic          carry;
    r     = v;
    all9  = 1'b1;
    carry = 1'b1;
    for (int i = 2; i < NDIG; i++) begin
      all9 = all9 & (v[4*i +: 4] == 4'd9);
    end
    if (v[7:4] > 4'd5) begin
      if (all9) begin
        r[7:0] = 8'h59;
      end else begin
        r[7:4] = v[7:4] - 4'd6;
        for (int i = 2; i < NDIG; i++) begin
          if (carry && (v[4*i +: 4] == 4'd9)) begin
            r[4*i +: 4] = 4'd0;
          end else if (carry) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4];
          end
        end
      end
    end else begin
      r = v;
    end
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_startn   <= 1'b1;
      r_startn_d <= 1'b1;
      r_stopn    <= 1'b1;
      r_stopn_d  <= 1'b1;
      r_clearn   <= 1'b1;
      r_clearn_d <= 1'b1;
      r_key      <= 10'd0;
      r_key_d    <= 10'd0;
    end else begin
      r_startn   <= startn;
      r_startn_d <= r_startn;
      r_stopn    <= stopn;
      r_stopn_d  <= r_stopn;
      r_clearn   <= clearn;
      r_clearn_d <= r_clearn;
      r_key      <= keypad;
      r_key_d    <= r_key;
    end
  end

  assign w_start_ev = r_startn_d & ~r_startn;
  assign w_stop_ev  = r_stopn_d & ~r_stopn;
  assign w_clear_ev = r_clearn_d & ~r_clearn;
  assign w_key_ev   = (r_key_d == 10'd0) && $onehot(r_key);
  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_nonzero  = |r_digits;
  assign w_last_sec = (r_digits == DW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Event priority: clear, stop, door open, start, key.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift      = 1'b0;
    w_norm       = 1'b0;
    w_dec        = 1'b0;
    w_clr_digits = 1'b0;
    if (w_clear_ev) begin
      w_clr_digits = 1'b1;
      w_state_nxt  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_stop_ev && w_key_ev) begin
            w_shift     = 1'b1;
            w_state_nxt = S_ENTRY;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ENTRY: begin
          if (w_stop_ev) begin
            w_state_nxt = S_ENTRY;
          end else if (w_start_ev) begin
            w_norm      = door_closed & w_nonzero;
            w_state_nxt = (door_closed && w_nonzero) ? S_COOKING : S_ENTRY;
          end else if (w_key_ev) begin
            w_shift     = 1'b1;
            w_state_nxt = S_ENTRY;
          end else begin
            w_state_nxt = S_ENTRY;
          end
        end
        S_COOKING: begin
          if (w_stop_ev || !door_closed) begin
            w_state_nxt = S_PAUSED;
          end else if (w_tick) begin
            w_dec       = 1'b1;
            w_state_nxt = w_last_sec ? S_DONE : S_COOKING;
          end else begin
            w_state_nxt = S_COOKING;
          end
        end
        S_PAUSED: begin
          if (w_stop_ev) begin
            w_clr_digits = 1'b1;
            w_state_nxt  = S_IDLE;
          end else if (w_start_ev && door_closed) begin
            w_state_nxt = S_COOKING;
          end else begin
            w_state_nxt = S_PAUSED;
          end
        end
        S_DONE: begin
          if (w_stop_ev || (w_tick && (r_alarm_cnt == ALARM_MAX))) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_clr_digits = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      endcase
    end
  end

  // Door state acts combinationally so opening it cuts power before the state register reacts.
  always_comb begin
    mag_on = (r_state == S_COOKING) & door_closed & w_gate;
  end

  assign w_start_cook = (r_state == S_ENTRY) && (w_state_nxt == S_COOKING);
  assign w_presc_clr  = w_start_cook || (w_state_nxt == S_IDLE) || (w_state_nxt == S_ENTRY) ||
                        ((r_state == S_COOKING) && (w_state_nxt == S_DONE));
  assign w_presc_run  = ((r_state == S_COOKING) && (w_state_nxt == S_COOKING)) ||
                        ((r_state == S_DONE) && (w_state_nxt == S_DONE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digits <= {DW{1'b0}};
    end else if (w_clr_digits) begin
      r_digits <= {DW{1'b0}};
    end else if (w_norm) begin
      r_digits <= normalise(r_digits);
    end else if (w_dec) begin
      r_digits <= bcd_dec(r_digits);
    end else if (w_shift) begin
      r_digits <= {r_digits[DW-5:0], key_index(r_key)};
    end else begin
      r_digits <= r_digits;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= {PW{1'b0}};
    end else if (w_presc_clr) begin
      r_presc <= {PW{1'b0}};
    end else if (w_presc_run) begin
      r_presc <= w_tick ? {PW{1'b0}} : r_presc + PW'(1);
    end else begin
      r_presc <= r_presc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alarm_cnt <= {AW{1'b0}};
    end else if (r_state != S_DONE) begin
      r_alarm_cnt <= {AW{1'b0}};
    end else if (w_tick) begin
      r_alarm_cnt <= r_alarm_cnt + AW'(1);
    end else begin
      r_alarm_cnt <= r_alarm_cnt;
    end
  end

`ifdef MWC_POWER_LEVEL_EN
  logic [3:0] r_level, r_window;

  // Out-of-range levels run at full power.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_level  <= 4'd10;
      r_window <= 4'd0;
    end else if (w_start_cook) begin
      r_level  <= ((power_level == 4'd0) || (power_level > 4'd10)) ? 4'd10 : power_level;
      r_window <= 4'd0;
    end else if (w_dec) begin
      r_window <= (r_window == 4'd9) ? 4'd0 : r_window + 4'd1;
    end else begin
      r_level  <= r_level;
      r_window <= r_window;
    end
  end

  assign w_gate = (r_window < r_level);
`else
  assign w_gate = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cooking    <= 1'b0;
      r_done_alarm <= 1'b0;
    end else begin
      r_cooking    <= (w_state_nxt == S_COOKING);
      r_done_alarm <= (w_state_nxt == S_DONE);
    end
  end

  assign digits     = r_digits;
  assign cooking    = r_cooking;
  assign done_alarm = r_done_alarm;

endmodule

// File: tb/tb_microwave_ctrl_gen2.sv
// Bench for microwave_ctrl_gen2: time-in-seconds reference model, directed scenarios and random cooks.
module tb_microwave_ctrl_gen2;
  localparam int TICK_DIV    = 4;
  localparam int MIN_DIGITS  = 1;
  localparam int ALARM_TICKS = 3;
  localparam int DW          = 4 * (MIN_DIGITS + 2);
  localparam int ST_IDLE = 0, ST_ENTRY = 1, ST_COOK = 2, ST_PAUSE = 3, ST_DONE = 4;
  localparam int EV_NONE = 0, EV_CLEAR = 1, EV_STOP = 2, EV_START = 3, EV_KEY = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [9:0]    keypad;
  logic          startn, stopn, clearn, door_closed;
  logic [DW-1:0] digits;
  logic          mag_on, cooking, done_alarm;
`ifdef MWC_POWER_LEVEL_EN
  logic [3:0]    power_level;
  int            m_win, m_level;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_st, m_d0, m_d1, m_d2, m_secs, m_ph, m_alarm;

  microwave_ctrl_gen2 #(.TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIGITS), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clock(clock), .reset(reset), .keypad(keypad), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed),
`ifdef MWC_POWER_LEVEL_EN
    .power_level(power_level),
`endif
    .digits(digits), .mag_on(mag_on), .cooking(cooking), .done_alarm(done_alarm));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_st = ST_IDLE; m_d0 = 0; m_d1 = 0; m_d2 = 0; m_secs = 0; m_ph = 0; m_alarm = 0;
`ifdef MWC_POWER_LEVEL_EN
    m_win = 0; m_level = 10;
`endif
  endfunction

  // Expected display: raw keyed digits before cooking, mm:ss of remaining seconds afterwards.
  function automatic logic [DW-1:0] exp_digits();
    int m, t, u;
    if (m_st == ST_IDLE || m_st == ST_ENTRY) begin
      m = m_d2; t = m_d1; u = m_d0;
    end else if (m_st == ST_DONE) begin
      m = 0; t = 0; u = 0;
    end else begin
      m = m_secs / 60; t = (m_secs % 60) / 10; u = m_secs % 10;
    end
    return {4'(m), 4'(t), 4'(u)};
  endfunction

  function automatic logic exp_mag();
    logic g;
    g = 1'b1;
`ifdef MWC_POWER_LEVEL_EN
    g = (m_win < m_level);
`endif
    return (m_st == ST_COOK) && door_closed && g;
  endfunction

  function automatic logic [DW+2:0] exp_vec();
    return {exp_digits(), (m_st == ST_COOK), (m_st == ST_DONE), exp_mag()};
  endfunction

  function automatic logic [DW+2:0] obs();
    return {digits, cooking, done_alarm, mag_on};
  endfunction

  // One clock edge of the reference model, with at most one (highest-priority) event.
  function automatic void model_edge(input int ev, input int kv);
    int total;
    if (ev == EV_CLEAR) begin
      model_reset();
    end else if (ev == EV_STOP && (m_st == ST_COOK)) begin
      m_st = ST_PAUSE;
    end else if (ev == EV_STOP && (m_st == ST_PAUSE || m_st == ST_DONE)) begin
      model_reset();
    end else if (ev == EV_STOP) begin
      m_st = m_st;
    end else if (m_st == ST_IDLE || m_st == ST_ENTRY) begin
      total = m_d2 * 60 + m_d1 * 10 + m_d0;
      if (ev == EV_KEY) begin
        m_d2 = m_d1; m_d1 = m_d0; m_d0 = kv; m_st = ST_ENTRY;
      end else if (ev == EV_START && m_st == ST_ENTRY && door_closed && total != 0) begin
        m_secs = (total > 599) ? 599 : total;
        m_ph = 0; m_st = ST_COOK;
`ifdef MWC_POWER_LEVEL_EN
        m_win = 0;
        m_level = (power_level == 0 || power_level > 10) ? 10 : int'(power_level);
`endif
      end
    end else if (m_st == ST_COOK) begin
      if (!door_closed) begin
        m_st = ST_PAUSE;
      end else begin
        m_ph++;
        if (m_ph == TICK_DIV) begin
          m_ph = 0; m_secs--;
`ifdef MWC_POWER_LEVEL_EN
          m_win = (m_win + 1) % 10;
`endif
          if (m_secs == 0) begin m_st = ST_DONE; m_alarm = 0; end
        end
      end
    end else if (m_st == ST_PAUSE) begin
      if (ev == EV_START && door_closed) m_st = ST_COOK;
    end else if (m_st == ST_DONE) begin
      m_ph++;
      if (m_ph == TICK_DIV) begin
        m_ph = 0; m_alarm++;
        if (m_alarm == ALARM_TICKS) model_reset();
      end
    end
  endfunction

  task automatic tick_edge(input int ev, input int kv);
    @(posedge clock);
    model_edge(ev, kv);
    @(negedge clock);
  endtask

  task automatic press(input logic c, input logic s, input logic st);
    int ev;
    ev = c ? EV_CLEAR : (s ? EV_STOP : EV_START);
    clearn = ~c; stopn = ~s; startn = ~st;
    tick_edge(EV_NONE, 0);
    tick_edge(ev, 0);
    clearn = 1'b1; stopn = 1'b1; startn = 1'b1;
    tick_edge(EV_NONE, 0);
    tick_edge(EV_NONE, 0);
  endtask

  task automatic key(input int k);
    keypad = 10'd1 << k;
    tick_edge(EV_NONE, 0);
    tick_edge(EV_KEY, k);
    keypad = 10'd0;
    tick_edge(EV_NONE, 0);
    tick_edge(EV_NONE, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
`ifdef MWC_POWER_LEVEL_EN
    power_level = 4'd10;
`endif
    model_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if (obs() !== {(DW+3){1'b0}}) begin
      n_errors++; $display("FAIL reset_hold: got %h expected 0", obs());
    end
    reset = 1'b0;
    tick_edge(EV_NONE, 0);
    n_checks++;
    if (obs() !== exp_vec()) begin
      n_errors++; $display("FAIL reset_release: got %h expected %h", obs(), exp_vec());
    end
  endtask

  task automatic test_entry_normalise();
    logic [DW-1:0] want [3];
    int keys [3];
    want = '{12'h001, 12'h017, 12'h175};
    keys = '{1, 7, 5};
    for (int i = 0; i < 3; i++) begin
      key(keys[i]);
      n_checks++;
      if (digits !== want[i] || obs() !== exp_vec()) begin
        n_errors++; $display("FAIL entry_key%0d: got %h expected digits %h vec %h", i, obs(), want[i], exp_vec());
      end
    end
    press(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (digits !== 12'h215 || cooking !== 1'b1 || mag_on !== 1'b1 || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL normalise: got %h expected 215/1/0/1 model %h", obs(), exp_vec());
    end
    tick_edge(EV_NONE, 0);
    n_checks++;
    if (digits !== 12'h215) begin
      n_errors++; $display("FAIL first_tick_early: got %h expected 215", digits);
    end
    tick_edge(EV_NONE, 0);
    n_checks++;
    if (digits !== 12'h214 || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL first_tick: got %h expected 214 model %h", obs(), exp_vec());
    end
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_countdown_done();
    int n_alarm;
    n_alarm = 0;
    key(0); key(0); key(2);
    press(1'b0, 1'b0, 1'b1);
    n_alarm += (done_alarm === 1'b1) ? 1 : 0;
    for (int i = 0; i < 60 && m_st != ST_IDLE; i++) begin
      tick_edge(EV_NONE, 0);
      n_alarm += (done_alarm === 1'b1) ? 1 : 0;
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_errors++; $display("FAIL countdown cyc%0d: got %h expected %h", i, obs(), exp_vec());
      end
    end
    n_checks++;
    if (n_alarm != TICK_DIV * ALARM_TICKS || m_st != ST_IDLE) begin
      n_errors++; $display("FAIL alarm_len: got %0d cycles expected %0d", n_alarm, TICK_DIV * ALARM_TICKS);
    end
  endtask

  task automatic test_door_pause();
    key(3); key(0);
    press(1'b0, 1'b0, 1'b1);
    repeat (5) tick_edge(EV_NONE, 0);
    door_closed = 1'b0;
    #1;
    n_checks++;
    if (mag_on !== 1'b0 || cooking !== 1'b1 || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL door_mag_drop: got %h expected %h", obs(), exp_vec());
    end
    for (int i = 0; i < 10; i++) begin
      tick_edge(EV_NONE, 0);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_errors++; $display("FAIL paused cyc%0d: got %h expected %h", i, obs(), exp_vec());
      end
    end
    door_closed = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick_edge(EV_NONE, 0);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_errors++; $display("FAIL resume cyc%0d: got %h expected %h", i, obs(), exp_vec());
      end
    end
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== {(DW+3){1'b0}} || m_st != ST_IDLE) begin
      n_errors++; $display("FAIL stop_stop: got %h expected 0", obs());
    end
  endtask

  task automatic test_priority();
    key(4); key(2);
    press(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== {(DW+3){1'b0}} || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL clear_over_start: got %h expected 0", obs());
    end
    press(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (cooking !== 1'b0 || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL start_idle: got %h expected %h", obs(), exp_vec());
    end
    key(0);
    press(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (cooking !== 1'b0 || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL start_zero: got %h expected %h", obs(), exp_vec());
    end
    key(5);
    door_closed = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (cooking !== 1'b0 || digits !== 12'h005 || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL start_door_open: got %h expected %h", obs(), exp_vec());
    end
    door_closed = 1'b1;
    key(9); key(8); key(7);
    press(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (digits !== 12'h959 || obs() !== exp_vec()) begin
      n_errors++; $display("FAIL saturate: got %h expected 959 model %h", obs(), exp_vec());
    end
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midcook();
    key(9);
    press(1'b0, 1'b0, 1'b1);
    repeat (3) tick_edge(EV_NONE, 0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs() !== {(DW+3){1'b0}}) begin
      n_errors++; $display("FAIL async_reset: got %h expected 0", obs());
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    keypad = 10'b0000000011;
    for (int i = 0; i < 6; i++) begin
      tick_edge(EV_NONE, 0);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_errors++; $display("FAIL multibit_key cyc%0d: got %h expected %h", i, obs(), exp_vec());
      end
    end
    keypad = 10'd0;
    tick_edge(EV_NONE, 0);
    tick_edge(EV_NONE, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int nk, ncyc;
      nk = $urandom_range(1, 3);
      ncyc = $urandom_range(5, 60);
      for (int j = 0; j < nk; j++) key($urandom_range(0, 9));
`ifdef MWC_POWER_LEVEL_EN
      power_level = 4'($urandom_range(0, 15));
`endif
      press(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < ncyc; c++) begin
        if ($urandom_range(0, 15) == 0) door_closed = ~door_closed;
        tick_edge(EV_NONE, 0);
        n_checks++;
        if (obs() !== exp_vec()) begin
          n_errors++; $display("FAIL random it%0d cyc%0d: got %h expected %h", it, c, obs(), exp_vec());
        end
      end
      door_closed = 1'b1;
      press(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_errors++; $display("FAIL random_resume it%0d: got %h expected %h", it, obs(), exp_vec());
      end
      press(1'b1, 1'b0, 1'b0);
    end
  endtask

`ifdef MWC_POWER_LEVEL_EN
  task automatic test_power_level();
    power_level = 4'd3;
    key(2); key(0);
    press(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 130 && m_st != ST_IDLE; i++) begin
      door_closed = (i >= 50 && i < 56) ? 1'b0 : 1'b1;
      if (i == 60) press(1'b0, 1'b0, 1'b1);
      else tick_edge(EV_NONE, 0);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_errors++; $display("FAIL power cyc%0d: got %h expected %h", i, obs(), exp_vec());
      end
    end
    press(1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_entry_normalise();
    test_countdown_done();
    test_door_pause();
    test_priority();
    test_reset_midcook();
`ifdef MWC_POWER_LEVEL_EN
    test_power_level();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
